// File: rtl/hpu_pkg.sv
// hpu_pkg: shared definitions for the HPU control/status register block.
//   - Byte offsets of every register in the AXI4-Lite map.
//   - Bit positions inside CTRL and STATUS.
//   - AXI response codes.
//   - Bus FSM state encoding.
//   - Byte-lane merge helper used by every RW register.
package hpu_pkg;

  localparam logic [31:0] HPU_REG_CTRL     = 32'h00;
  localparam logic [31:0] HPU_REG_STATUS   = 32'h04;
  localparam logic [31:0] HPU_REG_ADDR_I   = 32'h08;
  localparam logic [31:0] HPU_REG_ADDR_J   = 32'h0C;
  localparam logic [31:0] HPU_REG_ITEM_NUM = 32'h10;
  localparam logic [31:0] HPU_REG_ITEM_A   = 32'h14;
  localparam logic [31:0] HPU_REG_USER0    = 32'h20;

  localparam int CTRL_GEN_BIT    = 0;
  localparam int CTRL_RUN_BIT    = 1;
  localparam int STATUS_DONE_BIT = 0;
  localparam int STATUS_BUSY_BIT = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Write path: IDLE/AW/W/RESP. Read path: RADDR/RDATA, entered from IDLE only.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_RESP,
    ST_RADDR,
    ST_RDATA
  } axi_state_e;

  // Replace only the byte lanes whose strobe is set.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/hpu_gen_counter.sv
// hpu_gen_counter: item-memory generation sequencer.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   start_i            software wrote CTRL with gen=1 (restarts from item_a=0)
//   abort_i            software wrote CTRL with gen=0 (stops, no done, no pulse)
//   item_num_i         last index to generate (inclusive)
//   gen_o              generation active
//   done_o             sticky completion flag, cleared by start_i
//   gen_done_o         one-cycle pulse on automatic completion
//   item_a_o           current generation index
module hpu_gen_counter #(
  parameter int ITEM_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ITEM_W-1:0] item_num_i,
  output logic              gen_o,
  output logic              done_o,
  output logic              gen_done_o,
  output logic [ITEM_W-1:0] item_a_o
);

  logic              gen_q;
  logic              done_q;
  logic              gen_done_q;
  logic [ITEM_W-1:0] item_a_q;

  // Software writes take priority over the automatic clear, so a CTRL write
  // landing on the final cycle suppresses the done flag and the pulse.
  // item_a wraps naturally if item_num is lowered below it mid-run.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gen_q      <= 1'b0;
      done_q     <= 1'b0;
      gen_done_q <= 1'b0;
      item_a_q   <= '0;
    end else begin
      gen_done_q <= 1'b0;
      if (start_i) begin
        gen_q    <= 1'b1;
        done_q   <= 1'b0;
        item_a_q <= '0;
      end else if (abort_i) begin
        gen_q <= 1'b0;
      end else if (gen_q) begin
        if (item_a_q == item_num_i) begin
          gen_q      <= 1'b0;
          done_q     <= 1'b1;
          gen_done_q <= 1'b1;
        end else begin
          item_a_q <= item_a_q + 1'b1;
        end
      end
    end
  end

  assign gen_o      = gen_q;
  assign done_o     = done_q;
  assign gen_done_o = gen_done_q;
  assign item_a_o   = item_a_q;

endmodule

// File: rtl/hpu_ctrl_regs.sv
// hpu_ctrl_regs: AXI4-Lite control/status register file for the HPU.
// Ports:
//   S_AXI_*      AXI4-Lite slave (clock, async active-low reset, AW/W/B/AR/R)
//   run          datapath run enable (CTRL[1])
//   gen          item-memory generation active (CTRL[0] / STATUS[1])
//   addr_i/j     programmed loop bounds
//   item_num     item-memory count (last generated index)
//   item_a       current generation index
//   gen_done     one-cycle pulse on automatic generation completion
//   user_regs    flattened general-purpose registers, reg k at [32k+31:32k]
// Build option: define HPU_REGS_SLVERR_EN to answer SLVERR for unmapped
// accesses and for writes to STATUS/ITEM_A; otherwise every response is OKAY.
module hpu_ctrl_regs
  import hpu_pkg::*;
#(
  parameter int ADDR_W        = 12,
  parameter int NUM_USER_REGS = 4,
  parameter int ITEM_W        = 16,
  parameter int PARAM_W       = 20
) (
  input  logic                       S_AXI_ACLK,
  input  logic                       S_AXI_ARESETN,
  input  logic [ADDR_W-1:0]          S_AXI_AWADDR,
  input  logic                       S_AXI_AWVALID,
  output logic                       S_AXI_AWREADY,
  input  logic [31:0]                S_AXI_WDATA,
  input  logic [3:0]                 S_AXI_WSTRB,
  input  logic                       S_AXI_WVALID,
  output logic                       S_AXI_WREADY,
  output logic [1:0]                 S_AXI_BRESP,
  output logic                       S_AXI_BVALID,
  input  logic                       S_AXI_BREADY,
  input  logic [ADDR_W-1:0]          S_AXI_ARADDR,
  input  logic                       S_AXI_ARVALID,
  output logic                       S_AXI_ARREADY,
  output logic [31:0]                S_AXI_RDATA,
  output logic [1:0]                 S_AXI_RRESP,
  output logic                       S_AXI_RVALID,
  input  logic                       S_AXI_RREADY,
  output logic                       run,
  output logic                       gen,
  output logic [PARAM_W-1:0]         addr_i,
  output logic [PARAM_W-1:0]         addr_j,
  output logic [ITEM_W-1:0]          item_num,
  output logic [ITEM_W-1:0]          item_a,
  output logic                       gen_done,
  output logic [32*NUM_USER_REGS-1:0] user_regs
);

  // Byte address with the lane bits dropped, widened for comparison with
  // the 32-bit offsets in the package.
  function automatic logic [31:0] word_addr(input logic [ADDR_W-1:0] a);
    return 32'(a) & 32'hFFFF_FFFC;
  endfunction

  axi_state_e          state_q;
  logic [ADDR_W-1:0]   aw_addr_q;
  logic [ADDR_W-1:0]   ar_addr_q;
  logic [31:0]         wdata_q;
  logic [3:0]          wstrb_q;
  logic [31:0]         rdata_q;
  logic [1:0]          rresp_q;
  logic [1:0]          bresp_q;

  logic                run_q, run_d;
  logic [PARAM_W-1:0]  addr_i_q, addr_i_d;
  logic [PARAM_W-1:0]  addr_j_q, addr_j_d;
  logic [ITEM_W-1:0]   item_num_q, item_num_d;

  logic                gen_w, done_w;

  // ---------------- write beat assembly ----------------
  // A write commits on the cycle the FSM enters RESP; address and data come
  // either straight off the bus or from whichever half was latched earlier.
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = word_addr(S_AXI_AWADDR);
    wr_data = S_AXI_WDATA;
    wr_strb = S_AXI_WSTRB;
    case (state_q)
      ST_IDLE: wr_en = S_AXI_AWVALID & S_AXI_WVALID;
      ST_AW: begin
        wr_en   = S_AXI_WVALID;
        wr_addr = word_addr(aw_addr_q);
      end
      ST_W: begin
        wr_en   = S_AXI_AWVALID;
        wr_data = wdata_q;
        wr_strb = wstrb_q;
      end
      default: ;
    endcase
  end

  logic [31:0]              rd_addr;
  logic [NUM_USER_REGS-1:0] wr_user_sel;
  logic [NUM_USER_REGS-1:0] rd_user_hit;

  assign rd_addr = word_addr(ar_addr_q);

  // CTRL only changes when byte lane 0 is strobed; gen is never stored here,
  // it is turned into a start or abort command for the counter.
  logic ctrl_byte_wr;
  logic gen_start, gen_abort;

  assign ctrl_byte_wr = wr_en && (wr_addr == HPU_REG_CTRL) && wr_strb[0];
  assign gen_start    = ctrl_byte_wr &&  wr_data[CTRL_GEN_BIT];
  assign gen_abort    = ctrl_byte_wr && !wr_data[CTRL_GEN_BIT];

  always_comb begin
    run_d      = run_q;
    addr_i_d   = addr_i_q;
    addr_j_d   = addr_j_q;
    item_num_d = item_num_q;
    if (ctrl_byte_wr) run_d = wr_data[CTRL_RUN_BIT];
    if (wr_en && wr_addr == HPU_REG_ADDR_I)
      addr_i_d = PARAM_W'(apply_wstrb(32'(addr_i_q), wr_data, wr_strb));
    if (wr_en && wr_addr == HPU_REG_ADDR_J)
      addr_j_d = PARAM_W'(apply_wstrb(32'(addr_j_q), wr_data, wr_strb));
    if (wr_en && wr_addr == HPU_REG_ITEM_NUM)
      item_num_d = ITEM_W'(apply_wstrb(32'(item_num_q), wr_data, wr_strb));
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      run_q      <= 1'b0;
      addr_i_q   <= '0;
      addr_j_q   <= '0;
      item_num_q <= '0;
    end else begin
      run_q      <= run_d;
      addr_i_q   <= addr_i_d;
      addr_j_q   <= addr_j_d;
      item_num_q <= item_num_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_USER_REGS; gi++) begin : g_user
      localparam logic [31:0] USER_OFF = HPU_REG_USER0 + 32'(4 * gi);
      logic [31:0] user_q;

      assign wr_user_sel[gi] = (wr_addr == USER_OFF);
      assign rd_user_hit[gi] = (rd_addr == USER_OFF);

      always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) user_q <= '0;
        else if (wr_en && wr_user_sel[gi])
          user_q <= apply_wstrb(user_q, wr_data, wr_strb);
      end

      assign user_regs[32*gi +: 32] = user_q;
    end
  endgenerate

  // ---------------- read mux ----------------
  logic [31:0] rd_word;

  always_comb begin
    rd_word = '0;
    case (rd_addr)
      HPU_REG_CTRL: begin
        rd_word[CTRL_RUN_BIT] = run_q;
        rd_word[CTRL_GEN_BIT] = gen_w;
      end
      HPU_REG_STATUS: begin
        rd_word[STATUS_BUSY_BIT] = gen_w;
        rd_word[STATUS_DONE_BIT] = done_w;
      end
      HPU_REG_ADDR_I:   rd_word = 32'(addr_i_q);
      HPU_REG_ADDR_J:   rd_word = 32'(addr_j_q);
      HPU_REG_ITEM_NUM: rd_word = 32'(item_num_q);
      HPU_REG_ITEM_A:   rd_word = 32'(item_a);
      default: begin
        for (int k = 0; k < NUM_USER_REGS; k++) begin
          if (rd_user_hit[k]) rd_word = user_regs[32*k +: 32];
        end
      end
    endcase
  end

  // ---------------- response codes ----------------
  logic       wr_map_rw;
  logic       rd_map;
  logic [1:0] wr_resp;
  logic [1:0] rd_resp;

  assign wr_map_rw = (wr_addr inside {HPU_REG_CTRL, HPU_REG_ADDR_I,
                                      HPU_REG_ADDR_J, HPU_REG_ITEM_NUM})
                     || (|wr_user_sel);
  assign rd_map    = (rd_addr inside {HPU_REG_CTRL, HPU_REG_STATUS, HPU_REG_ADDR_I,
                                      HPU_REG_ADDR_J, HPU_REG_ITEM_NUM, HPU_REG_ITEM_A})
                     || (|rd_user_hit);

`ifdef HPU_REGS_SLVERR_EN
  assign wr_resp = wr_map_rw ? RESP_OKAY : RESP_SLVERR;
  assign rd_resp = rd_map    ? RESP_OKAY : RESP_SLVERR;
`else
  assign wr_resp = RESP_OKAY;
  assign rd_resp = RESP_OKAY;
  logic unused_map;
  assign unused_map = wr_map_rw ^ rd_map;
`endif

  // ---------------- bus FSM ----------------
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q   <= ST_IDLE;
      aw_addr_q <= '0;
      ar_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      bresp_q   <= RESP_OKAY;
    end else begin
      if (wr_en) bresp_q <= wr_resp;
      case (state_q)
        ST_IDLE: begin
          if (S_AXI_AWVALID && S_AXI_WVALID) begin
            state_q <= ST_RESP;
          end else if (S_AXI_AWVALID) begin
            aw_addr_q <= S_AXI_AWADDR;
            state_q   <= ST_AW;
          end else if (S_AXI_WVALID) begin
            wdata_q <= S_AXI_WDATA;
            wstrb_q <= S_AXI_WSTRB;
            state_q <= ST_W;
          end else if (S_AXI_ARVALID) begin
            ar_addr_q <= S_AXI_ARADDR;
            state_q   <= ST_RADDR;
          end
        end
        ST_AW:   if (S_AXI_WVALID)  state_q <= ST_RESP;
        ST_W:    if (S_AXI_AWVALID) state_q <= ST_RESP;
        ST_RESP: if (S_AXI_BREADY)  state_q <= ST_IDLE;
        ST_RADDR: begin
          rdata_q <= rd_word;
          rresp_q <= rd_resp;
          state_q <= ST_RDATA;
        end
        ST_RDATA: if (S_AXI_RREADY) state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // Writes win arbitration: a pending AW or W in IDLE holds off the read.
  assign S_AXI_AWREADY = (state_q == ST_IDLE) || (state_q == ST_W);
  assign S_AXI_WREADY  = (state_q == ST_IDLE) || (state_q == ST_AW);
  assign S_AXI_ARREADY = (state_q == ST_IDLE) && !S_AXI_AWVALID && !S_AXI_WVALID;
  assign S_AXI_BVALID  = (state_q == ST_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = (state_q == ST_RDATA);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

  hpu_gen_counter #(
    .ITEM_W(ITEM_W)
  ) u_gen_counter (
    .clk_i      (S_AXI_ACLK),
    .rst_ni     (S_AXI_ARESETN),
    .start_i    (gen_start),
    .abort_i    (gen_abort),
    .item_num_i (item_num_q),
    .gen_o      (gen_w),
    .done_o     (done_w),
    .gen_done_o (gen_done),
    .item_a_o   (item_a)
  );

  assign run      = run_q;
  assign gen      = gen_w;
  assign addr_i   = addr_i_q;
  assign addr_j   = addr_j_q;
  assign item_num = item_num_q;

endmodule
